// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM port between fetch and load/store requesters; optional ARB_RR_EN selects round-robin arbitration
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned LAT       = 1,
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;
    localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        owner;
    logic        discard;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wen;
    logic        inst_ok_q;
    logic        data_ok_q;

    logic        grant_inst;
    logic        grant_data;
    logic        accept_en;

`ifdef ARB_RR_EN
    logic        last_owner;

    // Round-robin: on a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (inst_req && data_req) begin
            grant_data = (last_owner == OWN_INST);
            grant_inst = (last_owner == OWN_DATA);
        end else begin
            grant_inst = inst_req;
            grant_data = data_req;
        end
    end

    // Remember who was granted most recently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_INST;
        end else if (inst_addr_ok || data_addr_ok) begin
            last_owner <= data_addr_ok ? OWN_DATA : OWN_INST;
        end
    end
`else
    // Fixed priority: loads/stores always beat instruction fetch.
    assign grant_data = data_req;
    assign grant_inst = inst_req & ~data_req;
`endif

    // Acceptance only in IDLE and never while reset is held, so addr_ok is 0 in reset.
    assign accept_en    = reset & (state == IDLE);
    assign inst_addr_ok = accept_en & grant_inst;
    assign data_addr_ok = accept_en & grant_data;

    // A cancel arriving during the response cycle still kills the fetch pulse.
    assign inst_data_ok = inst_ok_q & ~inst_cancel;
    assign data_data_ok = data_ok_q;

    assign sram_addr  = lat_addr;
    assign sram_wdata = lat_wdata;
    assign busy       = (state != IDLE);

    // Transaction sequencer: latch in IDLE, strobe SRAM in ISSUE, count latency in WAIT, respond in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            owner      <= OWN_INST;
            discard    <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_wen    <= 4'h0;
            sram_en    <= 1'b0;
            sram_wen   <= 4'h0;
            inst_ok_q  <= 1'b0;
            data_ok_q  <= 1'b0;
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_addr_ok) begin
                        owner     <= OWN_DATA;
                        lat_addr  <= data_addr & ADDR_MASK;
                        lat_wen   <= data_wen;
                        lat_wdata <= data_wdata;
                        sram_en   <= 1'b1;
                        sram_wen  <= data_wen;
                        discard   <= 1'b0;
                        state     <= ISSUE;
                    end else if (inst_addr_ok) begin
                        owner     <= OWN_INST;
                        lat_addr  <= inst_addr & ADDR_MASK;
                        lat_wen   <= 4'h0;
                        lat_wdata <= 32'h0;
                        sram_en   <= 1'b1;
                        sram_wen  <= 4'h0;
                        discard   <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    sram_en  <= 1'b0;
                    sram_wen <= 4'h0;
                    cnt      <= CNT_LOAD;
                    if (owner == OWN_INST && inst_cancel) begin
                        discard <= 1'b1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (owner == OWN_INST && inst_cancel) begin
                        discard <= 1'b1;
                    end
                    if (cnt == 3'd0) begin
                        if (owner == OWN_INST) begin
                            inst_rdata <= sram_rdata;
                        end else if (lat_wen == 4'h0) begin
                            data_rdata <= sram_rdata;
                        end
                        inst_ok_q <= (owner == OWN_INST) && !discard && !inst_cancel;
                        data_ok_q <= (owner == OWN_DATA);
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    inst_ok_q <= 1'b0;
                    data_ok_q <= 1'b0;
                    discard   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed scoreboard bench for sram_arbiter (LAT=1 and LAT=3 instances, follows ARB_RR_EN)
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rd;
        logic        ck;
        int          cy;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];
    exp_t d3q[$];

    logic last_model = 1'b0;

    // LAT = 1 instance
    logic        inst_req, inst_cancel, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wen;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en, busy;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata, sram_rdata;
    logic [3:0]  sram_wen;

    // LAT = 3 instance
    logic        l3_inst_req, l3_inst_cancel, l3_data_req;
    logic [31:0] l3_inst_addr, l3_data_addr, l3_data_wdata;
    logic [3:0]  l3_data_wen;
    logic        l3_inst_addr_ok, l3_inst_data_ok, l3_data_addr_ok, l3_data_data_ok, l3_sram_en, l3_busy;
    logic [31:0] l3_inst_rdata, l3_data_rdata, l3_sram_addr, l3_sram_wdata, l3_sram_rdata;
    logic [3:0]  l3_sram_wen;

    sram_arbiter #(.LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy)
    );

    sram_arbiter #(.LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .inst_req(l3_inst_req), .inst_addr(l3_inst_addr), .inst_cancel(l3_inst_cancel),
        .inst_addr_ok(l3_inst_addr_ok), .inst_data_ok(l3_inst_data_ok), .inst_rdata(l3_inst_rdata),
        .data_req(l3_data_req), .data_wen(l3_data_wen), .data_addr(l3_data_addr), .data_wdata(l3_data_wdata),
        .data_addr_ok(l3_data_addr_ok), .data_data_ok(l3_data_data_ok), .data_rdata(l3_data_rdata),
        .sram_en(l3_sram_en), .sram_wen(l3_sram_wen), .sram_addr(l3_sram_addr), .sram_wdata(l3_sram_wdata),
        .sram_rdata(l3_sram_rdata), .busy(l3_busy)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    // SRAM model for the LAT=1 instance: read data is valid only in the capture cycle
    initial begin : sram1
        int idx;
        sram_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (reset && sram_en) begin
                idx = int'(sram_addr[7:2]);
                if (sram_wen != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wen[b]) mem1[idx][8*b +: 8] = sram_wdata[8*b +: 8];
                end else begin
                    repeat (1) @(posedge clk);
                    #1 sram_rdata = mem1[idx];
                    @(posedge clk);
                    #1 sram_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    // SRAM model for the LAT=3 instance
    initial begin : sram3
        int idx;
        l3_sram_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (reset && l3_sram_en && l3_sram_wen == 4'h0) begin
                idx = int'(l3_sram_addr[7:2]);
                repeat (3) @(posedge clk);
                #1 l3_sram_rdata = mem3[idx];
                @(posedge clk);
                #1 l3_sram_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every data_ok pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (data_data_ok) begin
                chk("ok_exclusive", inst_data_ok, 1'b0);
                if (dq.size() == 0) chk("spurious_data_ok", data_data_ok, 1'b0);
                else begin
                    e = dq.pop_front();
                    chk("data_ok_cycle", cyc, e.cy);
                    if (e.ck) chk("data_rdata", data_rdata, e.rd);
                end
            end
            if (inst_data_ok) begin
                if (iq.size() == 0) chk("spurious_inst_data_ok", inst_data_ok, 1'b0);
                else begin
                    e = iq.pop_front();
                    chk("inst_ok_cycle", cyc, e.cy);
                    chk("inst_rdata", inst_rdata, e.rd);
                end
            end
            if (l3_data_data_ok) begin
                if (d3q.size() == 0) chk("l3_spurious_data_ok", l3_data_data_ok, 1'b0);
                else begin
                    e = d3q.pop_front();
                    chk("l3_data_ok_cycle", cyc, e.cy);
                    chk("l3_data_rdata", l3_data_rdata, e.rd);
                end
            end
        end
    end

    task automatic data_op(input string tag, input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        @(negedge clk);
        data_req = 1'b1; data_addr = addr; data_wen = wen; data_wdata = wdata;
        #1;
        chk({tag, "_addr_ok"}, data_addr_ok, 1'b1);
        dq.push_back('{exp_rd, (wen == 4'h0), cyc + 3});
        last_model = 1'b1;
        @(negedge clk);
        data_req = 1'b0;
        #1;
        chk({tag, "_sram_en_c1"}, sram_en, 1'b1);
        chk({tag, "_sram_addr"}, sram_addr, addr & 32'h1FFF_FFFF);
        chk({tag, "_sram_wen"}, sram_wen, wen);
        if (wen != 4'h0) chk({tag, "_sram_wdata"}, sram_wdata, wdata);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_no_addr_ok_c1"}, data_addr_ok, 1'b0);
        @(negedge clk);
        #1 chk({tag, "_sram_en_c2"}, sram_en, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk({tag, "_idle_c4"}, busy, 1'b0);
    endtask

    task automatic pair(input logic [31:0] ia, input logic [31:0] ie,
                        input logic [31:0] da, input logic [31:0] de);
        logic wd;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = ia; data_req = 1'b1; data_addr = da; data_wen = 4'h0;
`ifdef ARB_RR_EN
        wd = (last_model == 1'b0);
`else
        wd = 1'b1;
`endif
        #1;
        chk("pair_data_addr_ok", data_addr_ok, wd);
        chk("pair_inst_addr_ok", inst_addr_ok, !wd);
        if (wd) dq.push_back('{de, 1'b1, cyc + 3});
        else    iq.push_back('{ie, 1'b1, cyc + 3});
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (wd) data_req = 1'b0;
                else    inst_req = 1'b0;
            end
            #1 chk("pair_loser_held", wd ? inst_addr_ok : data_addr_ok, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("pair_loser_addr_ok_c4", wd ? inst_addr_ok : data_addr_ok, 1'b1);
        if (wd) iq.push_back('{ie, 1'b1, cyc + 3});
        else    dq.push_back('{de, 1'b1, cyc + 3});
        last_model = !wd;
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("pair_idle", busy, 1'b0);
    endtask

    initial begin : stim
        int          acc[$];
        logic [31:0] st_exp;
        int          guard;

        for (int i = 0; i < 64; i++) begin
            mem1[i] = pat(i);
            mem3[i] = pat(i);
        end
        mem1[4]  = 32'hDEAD_BEEF;
        mem3[16] = 32'h1234_5678;

        reset = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_cancel = 1'b0;
        data_req = 1'b1; data_addr = 32'h8000_0000; data_wen = 4'h0; data_wdata = 32'h0;
        l3_inst_req = 1'b0; l3_inst_addr = 32'h0; l3_inst_cancel = 1'b0;
        l3_data_req = 1'b0; l3_data_addr = 32'h0; l3_data_wen = 4'h0; l3_data_wdata = 32'h0;

        // reset state, with requests pending
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_wen", sram_wen, 4'h0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; reset = 1'b1;

        // contention: data first, fetch granted in cycle 4
        pair(32'hBFC0_0000, pat(0), 32'h8000_0020, pat(8));

        // single load, store, read-back
        data_op("load", 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF);
        data_op("store", 32'hA000_0004, 4'b0011, 32'h0000_1234, 32'h0);
        st_exp = pat(1);
        st_exp[15:0] = 16'h1234;
        data_op("readback", 32'h8000_0004, 4'h0, 32'h0, st_exp);

        // second contention after a data grant (round-robin hands it to fetch)
        pair(32'hBFC0_0014, pat(5), 32'h8000_0018, pat(6));

        // cancel during WAIT, busy drops and new fetch accepted in cycle 4
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        #1 chk("cancel_addr_ok", inst_addr_ok, 1'b1);
        last_model = 1'b0;
        @(negedge clk); inst_req = 1'b0;
        @(negedge clk); inst_cancel = 1'b1;
        @(negedge clk); inst_cancel = 1'b0;
        #1;
        chk("cancel_no_data_ok", inst_data_ok, 1'b0);
        chk("cancel_busy_c3", busy, 1'b1);
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
        #1;
        chk("cancel_busy_c4", busy, 1'b0);
        chk("cancel_reaccept", inst_addr_ok, 1'b1);
        iq.push_back('{pat(3), 1'b1, cyc + 3});
        @(negedge clk); inst_req = 1'b0;
        repeat (3) @(negedge clk);

        // cancel during RESP still suppresses the pulse
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        #1 chk("cancel_resp_addr_ok", inst_addr_ok, 1'b1);
        @(negedge clk); inst_req = 1'b0;
        @(negedge clk);
        @(negedge clk); inst_cancel = 1'b1;
        #1 chk("cancel_resp_no_ok", inst_data_ok, 1'b0);
        @(negedge clk); inst_cancel = 1'b0;

        // cancel in IDLE does not block acceptance or the response
        @(negedge clk);
        inst_req = 1'b1; inst_cancel = 1'b1; inst_addr = 32'hBFC0_0010;
        #1 chk("cancel_idle_addr_ok", inst_addr_ok, 1'b1);
        iq.push_back('{32'hDEAD_BEEF, 1'b1, cyc + 3});
        @(negedge clk); inst_req = 1'b0; inst_cancel = 1'b0;
        repeat (3) @(negedge clk);

        // cancel held throughout a load has no effect on it
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8000_0030; data_wen = 4'h0; inst_cancel = 1'b1;
        #1 chk("cancel_data_addr_ok", data_addr_ok, 1'b1);
        dq.push_back('{pat(12), 1'b1, cyc + 3});
        last_model = 1'b1;
        @(negedge clk); data_req = 1'b0;
        repeat (3) @(negedge clk);
        inst_cancel = 1'b0;

        // reset pulled low mid-WAIT
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8000_0010; data_wen = 4'h0;
        #1 chk("rstmid_addr_ok", data_addr_ok, 1'b1);
        @(negedge clk); data_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_sram_en", sram_en, 1'b0);
        chk("rstmid_sram_wen", sram_wen, 4'h0);
        chk("rstmid_data_ok", data_data_ok, 1'b0);
        chk("rstmid_data_rdata", data_rdata, 32'h0);
        chk("rstmid_inst_rdata", inst_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        last_model = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk("rstmid_idle_after", busy, 1'b0);

        // LAT = 3: latency and back-to-back acceptance every 6 cycles
        @(negedge clk);
        l3_data_req = 1'b1; l3_data_addr = 32'h8000_0040;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k == 1) chk("l3_sram_en_c1", l3_sram_en, 1'b1);
            if (k == 2) chk("l3_sram_en_c2", l3_sram_en, 1'b0);
            if (l3_data_addr_ok) begin
                acc.push_back(k);
                d3q.push_back('{32'h1234_5678, 1'b1, cyc + 5});
            end
        end
        @(negedge clk); l3_data_req = 1'b0;
        chk("l3_accept_count", acc.size(), 3);
        for (int i = 0; i < acc.size(); i++) chk("l3_accept_cycle", acc[i], 6 * i);

        // drain outstanding expectations with a bound
        guard = 0;
        while ((dq.size() + iq.size() + d3q.size()) != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #5;
        chk("drain_dq", dq.size(), 0);
        chk("drain_iq", iq.size(), 0);
        chk("drain_d3q", d3q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one synchronous SRAM port between the pipeline's instruction-fetch requester and its data (load/store) requester.
- Sits between the If/exe stages and the external SRAM.
- Accepts at most one outstanding transaction, sequences it through a fixed-latency SRAM access, and returns per-requester address/data handshakes. The pipeline uses these handshakes to stall.

Parameters:
- LAT, 1, SRAM read latency in cycles from the sram_en cycle to valid sram_rdata; legal range 1..7.
- ADDR_MASK, 32'h1FFFFFFF, AND-mask applied to every outgoing address (kseg0/1 to physical).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  32  fetch virtual address.
- inst_cancel  in  1  pipeline flush; discards an outstanding fetch.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid (1-cycle pulse).
- inst_rdata  out  32  fetched word.
- data_req  in  1  load/store request; held with fields until data_addr_ok.
- data_wen  in  4  byte write enables; 0 = load.
- data_addr  in  32  data virtual address.
- data_wdata  in  32  store data, already byte-lane aligned.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid / store complete (1-cycle pulse).
- data_rdata  out  32  loaded word.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  physical address (addr & ADDR_MASK).
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- busy  out  1  transaction outstanding (state != IDLE).

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Down-counter cnt is 3 bits wide.
- IDLE:
  - If any req is present, the winner's addr_ok is driven combinationally high in the same cycle.
  - The winner's id, masked address, wen and wdata are latched; inst requests latch wen = 0.
  - Next state is ISSUE.
  - With no req, stay in IDLE.
- Arbitration: when both requesters assert req, data wins (fixed priority). The loser's addr_ok stays 0 and it must keep req asserted.
- ISSUE: lasts exactly one cycle.
  - sram_en = 1; sram_wen, sram_addr and sram_wdata come from the registered latch.
  - cnt is loaded with LAT-1.
  - Next state is WAIT.
- WAIT:
  - sram_en = 0; cnt decrements each cycle.
  - When cnt == 0, sram_rdata is captured into a response register and the state goes to RESP.
  - With LAT = 1, WAIT lasts exactly one cycle.
- RESP:
  - Pulses the owner's data_ok for one cycle; rdata presents the captured word. Stores also pulse data_ok, with rdata don't-care.
  - Next state is IDLE.
  - The IDLE acceptance cycle can therefore follow immediately, giving a per-transaction latency of req → data_ok = LAT+2 cycles and a throughput of one transaction per LAT+3 cycles.
- inst_rdata and data_rdata hold their last captured value until the next capture for that owner.
- inst_cancel:
  - Asserted in ISSUE or WAIT while the owner is inst: sets a discard flag, and RESP then produces no inst_data_ok. Timing is otherwise unchanged.
  - Asserted in RESP: the pulse is still suppressed.
  - Asserted in IDLE: no effect, and inst_addr_ok is still allowed.
  - Has no effect on data transactions.
- Writes are never cancelled.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; cnt, the latch, the discard flag and both rdata registers clear to 0.
  - All outputs are 0: sram_en, sram_wen, addr_ok, data_ok, busy.
  - An outstanding transaction is dropped silently; after release no data_ok is produced for it.
- Both addr_ok signals are 0 outside IDLE.
- Both data_ok signals are never high in the same cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_owner register (reset value: inst) updates on each grant. On a simultaneous request, the grant goes to the requester that was not last_owner. Single requests are granted as normal.
- Undefined: fixed data-over-inst priority, and no last_owner register exists.

Test Plan:
- Single load: data_req, wen = 0, addr 0x8000_0010; SRAM returns 0xDEADBEEF with LAT = 1 → data_addr_ok in cycle 0, sram_en and sram_addr 0x0000_0010 in cycle 1, data_data_ok with 0xDEADBEEF in cycle 3.
- Contention: inst_req (0xBFC0_0000) and data_req (0x8000_0020) both asserted in cycle 0 → data is granted first and inst_addr_ok appears in cycle 4. With ARB_RR_EN, a second simultaneous pair is granted to inst.
- Store: data_wen 4'b0011, wdata 0x0000_1234, addr 0xA000_0004 → sram_wen 4'b0011, sram_addr 0x0000_0004 in cycle 1, data_data_ok in cycle 3.
- Cancel: inst fetch accepted in cycle 0, inst_cancel pulsed in cycle 2 → no inst_data_ok, busy drops in cycle 4, and a new inst_req is accepted in cycle 4.
- LAT = 3: load returns 0x12345678 → sram_en in cycle 1, data_data_ok in cycle 5; back-to-back requests are accepted every 6 cycles.
- Reset mid-WAIT: reset pulled low in cycle 2 → all outputs are 0 immediately (asynchronously); after release, no data_ok occurs and the FSM is in IDLE.
